rv_multicycle_ctrl: RTL
=======================

# rv_multicycle_ctrl

Multi-cycle control sequencer for the RISC-V core. It fetches each instruction over a ready-handshaked instruction port and holds it in an internal instruction register (IR). It then steps it through DECODE/EXEC/MEM/WB states and drives the datapath enables, including the immediate-format select consumed by the immediate generator. This allows the same datapath to run against memories with wait states; illegal opcodes halt the core.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_rdata  in  32  instruction word, sampled when imem_req && imem_ready
- imem_ready  in  1  instruction fetch complete
- dmem_ready  in  1  data access complete
- branch_taken  in  1  branch compare result from ALU, valid in EXEC
- imem_req  out  1  fetch request, held until imem_ready
- dmem_req  out  1  data access request, held until dmem_ready
- dmem_we  out  1  store strobe, valid with dmem_req
- ir  out  32  current instruction register
- imm_sel  out  3  immediate format to immediate generator
- alu_a_pc  out  1  ALU operand A = PC (AUIPC, JAL)
- alu_b_imm  out  1  ALU operand B = immediate
- alu_op  out  2  0 ADD, 1 FUNCT (use funct3/funct7), 2 CMP, 3 PASS_B
- reg_we  out  1  register-file write enable
- wb_sel  out  2  0 ALU, 1 MEM, 2 PC+4
- pc_we  out  1  PC update enable
- pc_src  out  1  0 PC+4, 1 target
- halted  out  1  sticky illegal-instruction flag
- instret  out  32  retired-instruction counter

## Operation
- Opcodes decoded from ir[6:0]:
  - R 0110011: imm_sel NONE, alu_op FUNCT, wb_sel ALU.
  - OP-IMM 0010011: imm_sel I, alu_op FUNCT, wb_sel ALU.
  - LOAD 0000011: imm_sel I, alu_op ADD, wb_sel MEM.
  - STORE 0100011: imm_sel S, alu_op ADD.
  - BRANCH 1100011: imm_sel B, alu_op CMP.
  - JAL 1101111: imm_sel J, alu_a_pc=1, alu_op ADD, wb_sel PC+4.
  - LUI 0110111: imm_sel U, alu_op PASS_B, wb_sel ALU.
  - AUIPC 0010111: imm_sel U, alu_a_pc=1, alu_op ADD, wb_sel ALU.
  - Anything else is illegal.
- imm_sel encoding: I=0, S=1, B=2, J=3, U=4, NONE=7.
- alu_b_imm is 1 for every legal opcode except R.
- States and transitions:
  - FETCH: imem_req=1. On imem_ready, IR <= imem_rdata and go to DECODE; otherwise stay.
  - DECODE: illegal opcode goes to HALT; otherwise go to EXEC.
  - EXEC: LOAD/STORE go to MEM. BRANCH asserts pc_we with pc_src=branch_taken and goes to FETCH. All others go to WB.
  - MEM: dmem_req=1, dmem_we=STORE. On dmem_ready, LOAD goes to WB; STORE asserts pc_we, pc_src=0, and goes to FETCH.
  - WB: reg_we=1, pc_we=1, pc_src=(JAL) and go to FETCH.
  - HALT: halted=1, all enables 0, no exit except reset.
- Decode outputs (imm_sel, alu_*, wb_sel) derive from IR and are valid in DECODE through WB; they are don't-care in FETCH.
- reg_we, pc_we, imem_req, dmem_req and dmem_we are 0 outside the states listed above.
- instret increments by 1 on every cycle with pc_we=1 and wraps 0xFFFFFFFF -> 0.

## Timing
- Reset values, asserted asynchronously:
  - State = FETCH, IR = 32'h00000013 (NOP), instret = 0, halted = 0.
  - imem_req=0, all other enables 0 while rst_n=0.
  - The first cycle after deassertion drives imem_req=1.
- Latency with zero-wait memories (imem_ready/dmem_ready high in the first request cycle):
  - BRANCH: 3 cycles.
  - R, OP-IMM, LUI, AUIPC, JAL: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds one cycle.
- imem_req/dmem_req stay asserted and stable until the ready handshake completes.
- A ready input arriving without a matching request is ignored.
- pc_we in MEM is combinational on dmem_ready (Mealy). All other outputs depend only on the registered state and IR.
- Reset during MEM or FETCH aborts the access immediately; requests drop with rst_n.
- In HALT, imem_ready/dmem_ready toggling has no effect and instret is frozen.

## Structure
- Shared package rv_ctrl_pkg holds:
  - opcode constants;
  - imm_sel, alu_op and wb_sel encodings;
  - the state enum (FETCH, DECODE, EXEC, MEM, WB, HALT).
- One combinational sub-module, rv_opcode_decode: takes ir[6:0] and produces illegal, imm_sel, alu_a_pc, alu_b_imm, alu_op, wb_sel and class flags (is_load/is_store/is_branch/is_jal).
- The top level holds the FSM, IR and instret.

## Test plan
- Reset, then imem_rdata=32'h00500093 (addi x1,x0,5) with zero wait:
  - imem_req on cycle 1;
  - DECODE shows imm_sel=0, alu_b_imm=1;
  - reg_we=1 and pc_we=1 on cycle 4;
  - instret=1.
- LW 32'h0000A103 with dmem_ready delayed 3 cycles:
  - dmem_req=1, dmem_we=0 held 4 cycles;
  - then WB with wb_sel=1;
  - total 8 cycles.
- SW 32'h0020A023:
  - MEM with dmem_we=1, imm_sel=1;
  - pc_we=1, pc_src=0 in the same cycle as dmem_ready;
  - reg_we never asserted.
- BEQ 32'h00000463, once with branch_taken=1 and once with branch_taken=0:
  - pc_src=1 vs 0 in EXEC;
  - 3-cycle instruction.
- JAL 32'h008000EF:
  - imm_sel=3, wb_sel=2, pc_src=1 in WB.
- Illegal word 32'hFFFFFFFF:
  - HALT after DECODE, halted=1, no further imem_req;
  - rst_n pulse low mid-HALT returns to FETCH with IR=32'h00000013 and instret=0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control sequencer:
// opcodes, datapath select codes and the sequencer state enum.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_J    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_FUNCT  = 2'd1;
  localparam logic [1:0] ALU_CMP    = 2'd2;
  localparam logic [1:0] ALU_PASS_B = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

endpackage

// File: rtl/rv_opcode_decode.sv
// Combinational opcode decoder: maps ir[6:0] to datapath selects and class flags.
// Zero latency; no handshake.
module rv_opcode_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       illegal,
  output logic [2:0] imm_sel,
  output logic       alu_a_pc,
  output logic       alu_b_imm,
  output logic [1:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jal
);

  always_comb begin
    illegal   = 1'b0;
    imm_sel   = IMM_NONE;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b1;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    case (opcode)
      OP_R: begin
        alu_b_imm = 1'b0;
        alu_op    = ALU_FUNCT;
      end
      OP_IMM: begin
        imm_sel = IMM_I;
        alu_op  = ALU_FUNCT;
      end
      OP_LOAD: begin
        imm_sel = IMM_I;
        wb_sel  = WB_MEM;
        is_load = 1'b1;
      end
      OP_STORE: begin
        imm_sel  = IMM_S;
        is_store = 1'b1;
      end
      OP_BRANCH: begin
        imm_sel   = IMM_B;
        alu_op    = ALU_CMP;
        is_branch = 1'b1;
      end
      OP_JAL: begin
        imm_sel  = IMM_J;
        alu_a_pc = 1'b1;
        wb_sel   = WB_PC4;
        is_jal   = 1'b1;
      end
      OP_LUI: begin
        imm_sel = IMM_U;
        alu_op  = ALU_PASS_B;
      end
      OP_AUIPC: begin
        imm_sel  = IMM_U;
        alu_a_pc = 1'b1;
      end
      default: begin
        illegal   = 1'b1;
        alu_b_imm = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with IR and retired-instruction counter.
// 3-5 cycles per instruction plus one per memory wait; requests held until ready; illegal opcode halts.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] ir,
  output logic [2:0]  imm_sel,
  output logic        alu_a_pc,
  output logic        alu_b_imm,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        pc_src,
  output logic        halted,
  output logic [31:0] instret
);

  state_t      state_q, state_d;
  logic [31:0] ir_q;
  logic [31:0] instret_q;
  logic        illegal, is_load, is_store, is_branch, is_jal;

  rv_opcode_decode u_dec (
    .opcode    (ir_q[6:0]),
    .illegal   (illegal),
    .imm_sel   (imm_sel),
    .alu_a_pc  (alu_a_pc),
    .alu_b_imm (alu_b_imm),
    .alu_op    (alu_op),
    .wb_sel    (wb_sel),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_jal    (is_jal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ir_q      <= IR_NOP;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && imem_ready) ir_q <= imem_rdata;
      if (pc_we) instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    case (state_q)
      FETCH: begin
        // State sits in FETCH throughout reset, so the request is gated by rst_n itself.
        imem_req = rst_n;
        if (imem_ready) state_d = DECODE;
      end
      DECODE: state_d = illegal ? HALT : EXEC;
      EXEC: begin
        if (is_load || is_store) begin
          state_d = MEM;
        end else if (is_branch) begin
          pc_we   = 1'b1;
          pc_src  = branch_taken;
          state_d = FETCH;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_load) begin
            state_d = WB;
          end else begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end
        end
      end
      WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        pc_src  = is_jal;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  assign ir      = ir_q;
  assign instret = instret_q;
  assign halted  = (state_q == HALT);

endmodule
